axi_lite_slave_mem: RTL
=======================

// Module: axi_lite_slave_mem
// PURPOSE
//   AXI4-Lite slave register memory: the downstream endpoint for the team's AXI-Lite write master.
//   Accepts single-beat writes with byte strobes and single-beat reads, and returns OKAY/SLVERR.
//   Counts error responses for debug visibility. Sits behind the interconnect inside design_1.
// PARAMETERS
//   DATA_WIDTH  32  data bus width; STRB_WIDTH = DATA_WIDTH/8
//   ADDR_WIDTH  32  address bus width
//   DEPTH       32  number of DATA_WIDTH words in the memory
//   ADDR_LSB    0   word index = addr >> ADDR_LSB (0: word-addressed, as driven by our master)
// PORTS
//   s_axi_aclk     in   1           clock, all logic on rising edge
//   s_axi_areset   in   1           reset, asynchronous, active-high
//   s_axi_awaddr   in   ADDR_WIDTH  write address
//   s_axi_awvalid  in   1           write address valid
//   s_axi_awready  out  1           write address ready
//   s_axi_wdata    in   DATA_WIDTH  write data
//   s_axi_wstrb    in   STRB_WIDTH  write byte strobes
//   s_axi_wvalid   in   1           write data valid
//   s_axi_wready   out  1           write data ready
//   s_axi_bresp    out  2           write response (00 OKAY, 10 SLVERR)
//   s_axi_bvalid   out  1           write response valid
//   s_axi_bready   in   1           write response ready
//   s_axi_araddr   in   ADDR_WIDTH  read address
//   s_axi_arvalid  in   1           read address valid
//   s_axi_arready  out  1           read address ready
//   s_axi_rdata    out  DATA_WIDTH  read data
//   s_axi_rresp    out  2           read response (00 OKAY, 10 SLVERR)
//   s_axi_rvalid   out  1           read data valid
//   s_axi_rready   in   1           read data ready
//   o_err_cnt      out  32          SLVERR count, saturating
// BEHAVIOUR
//   Reset (async assert, sync release): all outputs 0, all memory words 0, FSMs idle.
//     The readies rise on the first clock edge after reset is released.
//   Reset during any transaction aborts it: pending bvalid/rvalid drop at once; no memory write.
//   Write FSM W_IDLE -> W_RESP -> W_IDLE:
//     - W_IDLE: awready=1 until the AW beat is captured; wready=1 until the W beat is captured.
//     - AW and W may arrive in either order or in the same cycle; each is latched independently.
//     - At the edge where both are held, the memory is written, bvalid/bresp are registered
//       (bvalid visible the next cycle), and the FSM goes to W_RESP.
//     - W_RESP: awready=wready=0; bvalid and bresp are held stable until bready=1.
//     - After the B handshake, return to W_IDLE; readies reassert the following cycle.
//   Read FSM R_IDLE -> R_DATA -> R_IDLE:
//     - R_IDLE: arready=1. At the AR handshake edge, rdata/rresp are registered and rvalid=1.
//     - R_DATA: arready=0; rdata, rresp and rvalid are held until rready=1, then R_IDLE.
//   Address decode: idx = addr >> ADDR_LSB.
//     - idx >= DEPTH: SLVERR, no write; a read returns rdata = 0.
//     - Otherwise: OKAY.
//   Strobes: byte lane i of the word is updated iff wstrb[i]=1. wstrb=0 -> OKAY, word unchanged.
//   Read and write to the same word completing at the same edge: the read returns the OLD value.
//   The write and read channels are fully independent and may be active concurrently.
//   o_err_cnt: +1 per SLVERR response issued (counted at the issuing edge).
//     - A write SLVERR and a read SLVERR at the same edge: +2.
//     - Saturates at 32'hFFFF_FFFF.
//   Latency: address/data handshake -> response valid, 1 cycle. Throughput: 1 transaction per
//     3 cycles per channel with bready/rready tied high.
// TESTING
//   1. Write addr 1 = 0x15, then assert reset mid-read of addr 1 -> rvalid=0 at once;
//      after release, read addr 1 -> 0x0 OKAY.
//   2. AW+W same cycle, addr 1, data 0x15, strb F, bready=1 -> bvalid next cycle, bresp 00;
//      read addr 1 -> 0x15 OKAY.
//   3. W at cycle 0, AW at cycle 3, bready low for 4 cycles -> bvalid held stable,
//      awready=wready=0 throughout; a single write to memory.
//   4. Addr 3: write 0xAABBCCDD strb F, then 0x11223344 strb 4'b0101 -> read returns 0xAA22CC44.
//   5. Write addr 32 (DEPTH=32) data 0xDEADBEEF -> bresp 10, memory unchanged, o_err_cnt=1;
//      read addr 40 -> rdata 0, rresp 10, o_err_cnt=2.
//   6. Addr 2 holds 5; write 9 to addr 2 and AR addr 2 completing at the same edge -> rdata 5;
//      next read of addr 2 -> 9.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - AXI4-Lite slave word memory with byte strobes, SLVERR decode and error counter
module axi_lite_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_LSB    = 0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           o_err_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [31:0]           err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  aw_hs, w_hs, ar_hs, aw_have, w_have, w_fire, w_err, r_err, mem_we;
  logic [ADDR_WIDTH-1:0] waddr, widx_full, ridx_full;
  logic [IDX_W-1:0]      widx, ridx;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [STRB_WIDTH-1:0] wstrb_sel;
  logic [1:0]            err_inc;
  logic [32:0]           err_sum;

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign o_err_cnt     = err_cnt_q;

  // A beat counts as present if it was latched earlier or is being accepted this cycle
  assign aw_hs     = s_axi_awvalid && awready_q;
  assign w_hs      = s_axi_wvalid && wready_q;
  assign aw_have   = aw_held_q || aw_hs;
  assign w_have    = w_held_q || w_hs;
  assign w_fire    = (w_state_q == W_IDLE) && aw_have && w_have;
  assign waddr     = aw_held_q ? awaddr_q : s_axi_awaddr;
  assign wdata_sel = w_held_q ? wdata_q : s_axi_wdata;
  assign wstrb_sel = w_held_q ? wstrb_q : s_axi_wstrb;
  assign widx_full = waddr >> ADDR_LSB;
  assign widx      = widx_full[IDX_W-1:0];
  assign w_err     = widx_full >= ADDR_WIDTH'(DEPTH);
  assign mem_we    = w_fire && !w_err;

  assign ar_hs     = s_axi_arvalid && arready_q;
  assign ridx_full = s_axi_araddr >> ADDR_LSB;
  assign ridx      = ridx_full[IDX_W-1:0];
  assign r_err     = ridx_full >= ADDR_WIDTH'(DEPTH);

  // Write FSM: collect AW and W in any order, then issue one B response.
  // Readies are registered from the current state, so they return one idle cycle after a response.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_fire) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          aw_held_d = aw_have;
          w_held_d  = w_have;
          awready_d = !aw_have;
          wready_d  = !w_have;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel state, handshake registers and latched AW/W beats
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= wdata_sel;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  // Read FSM: capture data at the AR handshake (old memory contents), hold until rready
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d  = 1'b1;
          rdata_d   = r_err ? '0 : mem_q[ridx];
          rresp_d   = r_err ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel state and response registers
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Memory array: cleared on reset, byte-lane write when a decoded write fires
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_sel[b]) mem_q[widx][8*b +: 8] <= wdata_sel[8*b +: 8];
      end
    end
  end

  // Saturating SLVERR counter; a write and a read error on the same edge add two
  assign err_inc   = {1'b0, w_fire && w_err} + {1'b0, ar_hs && r_err};
  assign err_sum   = {1'b0, err_cnt_q} + {31'b0, err_inc};
  assign err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];

  // Error counter register
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) err_cnt_q <= '0;
    else              err_cnt_q <= err_cnt_d;
  end

endmodule
